// File: rtl/adc_snapshot_capture_if.sv
// Purpose : signal bundle between the ADC snapshot capture block and its user
//           (ADC slice data in, capture control in, debug readout out).
// Ports   : master = stimulus/control side, slave = capture block side.
interface adc_snapshot_capture_if #(
   parameter int Nti    = 16,
   parameter int Nadc   = 8,
   parameter int Ndepth = 32,
   parameter int Nhold  = 8
);
   // per-slice ADC outputs, sign 1 = positive
   logic [Nti-1:0][Nadc-1:0]     adder_out;
   logic [Nti-1:0]               sign_out;
   // capture control
   logic                         start;
   logic                         abort;
   logic                         trig_mode;
   logic                         trig_in;
   logic [Nhold-1:0]             holdoff;
   // readout
   logic [$clog2(Ndepth)-1:0]    rd_addr;
   logic [$clog2(Nti)-1:0]       rd_slice;
   logic [Nadc:0]                rd_data;
   // status
   logic                         busy;
   logic                         done;
   logic [$clog2(Ndepth):0]      wr_count;

   modport master (
      output adder_out, sign_out, start, abort, trig_mode, trig_in, holdoff,
             rd_addr, rd_slice,
      input  rd_data, busy, done, wr_count
   );

   modport slave (
      input  adder_out, sign_out, start, abort, trig_mode, trig_in, holdoff,
             rd_addr, rd_slice,
      output rd_data, busy, done, wr_count
   );
endinterface

// File: rtl/adc_snapshot_capture.sv
// Purpose : converts ADC slice sign/magnitude to two's complement and captures
//           a Ndepth-row burst of all slices into a register buffer for debug readout.
// Latency : 1 cycle input->buffer write data, 1 cycle rd_addr/rd_slice->rd_data.
// Backpressure: none; the ADC stream is free-running, rows outside a capture are dropped.
// Ports   : clk_adc/rstb plain; bus (slave) carries adder_out/sign_out, start/abort,
//           trig_mode/trig_in/holdoff, rd_addr/rd_slice -> rd_data, busy/done/wr_count.
module adc_snapshot_capture #(
   parameter int Nti    = 16,
   parameter int Nadc   = 8,
   parameter int Ndepth = 32,
   parameter int Nhold  = 8
) (
   input  logic                   clk_adc,
   input  logic                   rstb,
   adc_snapshot_capture_if.slave  bus
);
   localparam int AW = $clog2(Ndepth);
   localparam int DW = Nadc + 1;
   localparam logic [AW:0] LAST_ROW = (AW+1)'(Ndepth - 1);
   localparam logic [AW:0] DEPTH    = (AW+1)'(Ndepth);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_HOLD,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t                    r_state;
   logic [Nhold-1:0]          r_hold_cnt;
   logic [AW:0]               r_wr_count;
   logic                      r_done;
   logic [DW-1:0]             r_rd_data;
   logic [Nti-1:0][DW-1:0]    r_conv;
   logic [Nti-1:0][DW-1:0]    r_buf [Ndepth];

   logic [Nti-1:0][DW-1:0]    w_conv;
   logic                      w_wr_en;

   // Sign/magnitude -> two's complement; a negative zero naturally maps to 0.
   always_comb begin
      w_conv = '0;
      for (int k = 0; k < Nti; k++) begin
         if (bus.sign_out[k])
            w_conv[k] = {1'b0, bus.adder_out[k]};
         else
            w_conv[k] = DW'(0) - {1'b0, bus.adder_out[k]};
      end
   end

   always_ff @(posedge clk_adc or negedge rstb) begin
      if (!rstb)
         r_conv <= '0;
      else
         r_conv <= w_conv;
   end

   // The saturation guard keeps a stray CAPTURE cycle from ever writing past the last row.
   assign w_wr_en = (r_state == S_CAPTURE) && (r_wr_count < DEPTH);

   always_ff @(posedge clk_adc or negedge rstb) begin
      if (!rstb) begin
         r_state    <= S_IDLE;
         r_hold_cnt <= '0;
         r_wr_count <= '0;
         r_done     <= 1'b0;
      end else if (bus.abort) begin
         // wr_count deliberately kept so a partial capture is still visible
         r_state <= S_IDLE;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  r_done     <= 1'b0;
                  r_wr_count <= '0;
                  if (bus.trig_mode) begin
                     r_state <= S_ARMED;
                  end else begin
                     r_state    <= S_HOLD;
                     r_hold_cnt <= bus.holdoff;
                  end
               end
            end
            S_ARMED: begin
               if (bus.trig_in) begin
                  r_state    <= S_HOLD;
                  r_hold_cnt <= bus.holdoff;
               end
            end
            S_HOLD: begin
               // r_conv loaded on this exit edge becomes row 0
               if (r_hold_cnt == '0)
                  r_state <= S_CAPTURE;
               else
                  r_hold_cnt <= r_hold_cnt - 1'b1;
            end
            S_CAPTURE: begin
               if (w_wr_en) begin
                  r_wr_count <= r_wr_count + 1'b1;
                  if (r_wr_count == LAST_ROW) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Buffer has no reset: contents survive reset for post-mortem readout.
   always_ff @(posedge clk_adc) begin
      if (w_wr_en)
         r_buf[r_wr_count[AW-1:0]] <= r_conv;
   end

   always_ff @(posedge clk_adc or negedge rstb) begin
      if (!rstb)
         r_rd_data <= '0;
      else
         r_rd_data <= r_buf[bus.rd_addr][bus.rd_slice];
   end

   assign bus.rd_data  = r_rd_data;
   assign bus.busy     = (r_state == S_ARMED) || (r_state == S_HOLD) || (r_state == S_CAPTURE);
   assign bus.done     = r_done;
   assign bus.wr_count = r_wr_count;

endmodule

// File: doc/adc_snapshot_capture.md
Name: adc_snapshot_capture

Overview:
- Sits directly downstream of the 16-way time-interleaved ADC array, in the clk_adc domain.
- Converts each slice's sign/magnitude output (adder_out, sign_out) to signed two's complement.
- On command, captures a contiguous burst of all-slice samples into a register buffer.
- The buffer is read back one word at a time by the digital core's JTAG/debug register path, for link bring-up and ADC calibration.

Parameters:
Nti, 16, number of interleaved ADC slices per clk_adc cycle
Nadc, 8, magnitude width of adder_out per slice
Ndepth, 32, capture depth in clk_adc cycles (power of two)
Nhold, 8, width of holdoff counter

Ports:
clk_adc  input  1  ADC retiming clock; all logic is on the rising edge
rstb  input  1  asynchronous active-low reset
adder_out  input  Nadc x Nti  per-slice magnitude from the ADC array
sign_out  input  Nti  per-slice sign from the ADC array; 1 = positive
start  input  1  capture request, single-cycle pulse
abort  input  1  synchronous abort; returns to IDLE
trig_mode  input  1  0 = capture immediately after holdoff, 1 = wait for trig_in
trig_in  input  1  external trigger, level-sampled
holdoff  input  Nhold  cycles skipped between trigger/arm and first stored sample
rd_addr  input  log2(Ndepth)  readout row
rd_slice  input  log2(Nti)  readout slice
rd_data  output  Nadc+1  signed sample at [rd_addr][rd_slice]
busy  output  1  high in ARMED, HOLD, CAPTURE
done  output  1  high in DONE until next start, abort or reset
wr_count  output  log2(Ndepth)+1  rows stored in current/last capture

Behaviour:
- Reset (rstb low, async): state=IDLE; busy=0; done=0; wr_count=0; rd_data=0; holdoff counter=0. Buffer contents are not reset.
- Conversion, per slice:
  - sign=1 → +adder_out, zero-extended to Nadc+1.
  - sign=0 → −adder_out, two's complement in Nadc+1 bits.
  - Magnitude 0 with sign=0 yields 0.
  - Conversion is registered: one pipeline stage between the inputs and the buffer write data.
- State machine, evaluated each clk_adc:
  - IDLE:
    - start=1 → trig_mode=0 ? HOLD (counter loaded with holdoff) : ARMED.
    - Clears done and wr_count on the same edge.
  - ARMED: trig_in=1 → HOLD, counter loaded with holdoff.
  - HOLD:
    - counter==0 → CAPTURE; otherwise decrement.
    - holdoff=0 → exactly one cycle spent in HOLD.
  - CAPTURE:
    - Each cycle writes the registered converted row at index wr_count, then increments wr_count.
    - When wr_count reaches Ndepth → DONE.
    - First stored row is the ADC data present on the cycle HOLD exits, due to the 1-stage pipeline.
  - DONE:
    - done=1; buffer frozen.
    - start=1 → behaves as start in IDLE (new capture, done cleared).
- abort=1 in any state → IDLE next edge; busy=0, done=0; wr_count keeps its value (partial count visible). abort has priority over start on the same cycle.
- start while busy is ignored.
- trig_in in IDLE/HOLD/CAPTURE/DONE is ignored.
- Writes never wrap: wr_count saturates at Ndepth; no row beyond Ndepth-1 is written.
- Readout:
  - rd_data is registered from buffer[rd_addr][rd_slice], 1-cycle latency, valid in any state.
  - Reading a row during CAPTURE returns the old or new contents; that data is not guaranteed.
- busy = state∈{ARMED, HOLD, CAPTURE}, derived combinationally from the state register.

Test Plan:
1. Reset mid-CAPTURE (rstb low at wr_count=10) → busy=0, done=0, wr_count=0, rd_data=0 immediately (async); state IDLE after release.
2. trig_mode=0, holdoff=0, ADC ramp (slice k on cycle n: mag=(n+k)&0xFF, sign=1), start at cycle 0:
   - busy high 33 cycles, then done=1, wr_count=32.
   - Readback of each [r][k] matches the ramp value of the corresponding captured cycle; rd_data appears 1 cycle after the address.
3. Sign conversion, held inputs:
   - mag=5, sign=0 → rd_data=9'h1FB (−5).
   - mag=255, sign=0 → −255 (9'h101).
   - mag=0, sign=0 → 0.
   - mag=255, sign=1 → 9'h0FF.
4. trig_mode=1, holdoff=3, start, trig_in asserted 20 cycles later:
   - Remains ARMED (busy=1, wr_count=0) until the trigger.
   - First stored row equals ADC data 4 cycles after the trig_in sample.
   - done asserts Ndepth cycles later.
5. abort at wr_count=7 with start asserted the same cycle → IDLE, busy=0, done=0, wr_count=7. A start during CAPTURE of a later run does not restart it (wr_count monotonic).
6. start in DONE → done cleared next edge and a new capture begins; rows 0..31 are overwritten with new data.
